// File: rtl/johnson_pkg.sv
// Shared FSM encoding and error-counter limits for the Johnson phase monitor family.
// Pure declarations; no timing or flow-control behaviour.
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int unsigned            ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0]   ERR_CNT_MAX = 8'hFF;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational twisted-ring code to phase decoder; legal is low for any non-code pattern.
// Zero latency; no backpressure.
module johnson_decode #(
  parameter int SIZE = 7
) (
  input  logic [0:SIZE]                     code,
  output logic [$clog2(2*(SIZE+1))-1:0]     phase,
  output logic                              legal
);

  localparam int N  = SIZE + 1;
  localparam int PW = $clog2(2*N);

  // Phase p <= N fills ones from bit 0 upward; beyond N the ones drain from bit 0.
  function automatic logic [0:SIZE] code_of(input int p);
    logic [0:SIZE] c;
    for (int i = 0; i < N; i++) begin
      c[i] = (p <= N) ? (i < p) : (i >= p - N);
    end
    return c;
  endfunction

  always_comb begin
    phase = '0;
    legal = 1'b0;
    for (int p = 0; p < 2*N; p++) begin
      if (code == code_of(p)) begin
        phase = PW'(p);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter, decodes its phase, tracks lock and counts lock losses and revolutions.
// Latency 2 clocks jc_in -> phase/phase_vld; no backpressure, input is sampled every cycle.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int SIZE       = 7,
  parameter int LOCK_COUNT = 4,
  parameter int REV_W      = 16
) (
  input  logic                              clk,
  input  logic                              r,
  input  logic [0:SIZE]                     jc_in,
  input  logic                              clr,
  output logic [$clog2(2*(SIZE+1))-1:0]     phase,
  output logic                              phase_vld,
  output logic                              locked,
  output logic                              err,
  output logic [ERR_CNT_W-1:0]              err_cnt,
  output logic [REV_W-1:0]                  rev_cnt
);

  localparam int N  = SIZE + 1;
  localparam int PW = $clog2(2*N);
  localparam int AW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2*N - 1);

  logic [0:SIZE]          sample_q, sample_d;
  logic                   smp_vld_q, smp_vld_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   phase_vld_q, phase_vld_d;
  logic                   locked_q, locked_d;
  state_e                 state_q, state_d;
  logic [AW-1:0]          adv_q, adv_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [REV_W-1:0]       rev_cnt_q, rev_cnt_d;

  logic [PW-1:0]          dec_phase;
  logic                   dec_legal;
  logic                   cur_legal;
  logic [PW-1:0]          next_phase;
  logic                   is_hold, is_adv, step_ok;

  johnson_decode #(.SIZE(SIZE)) u_decode (
    .code  (sample_q),
    .phase (dec_phase),
    .legal (dec_legal)
  );

  always_comb begin
    sample_d    = jc_in;
    smp_vld_d   = 1'b1;
    // The sample register is meaningless until it has captured jc_in once after reset.
    cur_legal   = smp_vld_q & dec_legal;
    next_phase  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    is_hold     = (dec_phase == phase_q);
    is_adv      = (dec_phase == next_phase);
    step_ok     = cur_legal & (is_hold | is_adv);

    phase_d     = cur_legal ? dec_phase : phase_q;
    phase_vld_d = cur_legal;
    state_d     = state_q;
    adv_d       = adv_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    rev_cnt_d   = rev_cnt_q;

    case (state_q)
      ST_SEARCH: begin
        if (cur_legal) begin
          state_d = ST_TRACK;
          adv_d   = '0;
        end
      end
      ST_TRACK: begin
        if (!step_ok) begin
          state_d = ST_SEARCH;
          adv_d   = '0;
        end else if (is_adv) begin
          adv_d = adv_q + 1'b1;
          if (adv_q + 1'b1 == AW'(LOCK_COUNT)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!step_ok) begin
          state_d   = ST_SEARCH;
          adv_d     = '0;
          err_d     = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end else if (is_adv && (phase_q == PH_LAST)) begin
          rev_cnt_d = rev_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        adv_d   = '0;
      end
    endcase

    if (clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
      rev_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      sample_q    <= '0;
      smp_vld_q   <= 1'b0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      locked_q    <= 1'b0;
      state_q     <= ST_SEARCH;
      adv_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      rev_cnt_q   <= '0;
    end else begin
      sample_q    <= sample_d;
      smp_vld_q   <= smp_vld_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      locked_q    <= locked_d;
      state_q     <= state_d;
      adv_q       <= adv_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      rev_cnt_q   <= rev_cnt_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign rev_cnt   = rev_cnt_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomised and directed bench for johnson_phase_monitor against an integer-level lock model.
module tb_johnson_phase_monitor;

  localparam int N = 8;
  localparam int P = 2*N;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        clr = 1'b0;
  logic [0:7]  jc_in = '0;
  logic [3:0]  phase;
  logic        phase_vld, locked, err;
  logic [7:0]  err_cnt;
  logic [15:0] rev_cnt;

  int checks = 0;
  int passed = 0;
  int cur    = 0;

  // Reference model state (integers, not RTL encodings)
  logic [7:0] m_smp;
  bit         m_smp_v, m_vld, m_err;
  int         m_phase, m_mode, m_run, m_err_cnt, m_rev;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.SIZE(7), .LOCK_COUNT(4), .REV_W(16)) dut (
    .clk(clk), .r(r), .jc_in(jc_in), .clr(clr), .phase(phase), .phase_vld(phase_vld),
    .locked(locked), .err(err), .err_cnt(err_cnt), .rev_cnt(rev_cnt)
  );

  function automatic logic [7:0] code_of(input int p);
    int k;
    if (p <= N) return 8'(((1 << p) - 1) << (N - p));
    k = P - p;
    return 8'((1 << k) - 1);
  endfunction

  function automatic int model_decode(input logic [7:0] c);
    int k;
    k = $countones(c);
    if (c == 8'(((1 << k) - 1) << (N - k))) return k;
    if (k > 0 && k < N && c == 8'((1 << k) - 1)) return P - k;
    return -1;
  endfunction

  function automatic logic [30:0] exp_vec();
    return {m_vld, 4'(m_phase), (m_mode == 2), m_err, 8'(m_err_cnt), 16'(m_rev)};
  endfunction

  function automatic logic [30:0] act_vec();
    return {phase_vld, phase, locked, err, err_cnt, rev_cnt};
  endfunction

  task automatic model_step(input logic [7:0] code, input bit clr_v, input bit r_v);
    int d;
    bit ok, fwd, wrap;
    if (r_v) begin
      m_smp = '0; m_smp_v = 0; m_vld = 0; m_phase = 0; m_mode = 0; m_run = 0;
      m_err = 0; m_err_cnt = 0; m_rev = 0;
      return;
    end
    d    = m_smp_v ? model_decode(m_smp) : -1;
    fwd  = (d >= 0) && (d == (m_phase + 1) % P);
    ok   = (d >= 0) && (fwd || d == m_phase);
    wrap = fwd && (m_phase == P - 1);
    m_vld = (d >= 0);
    if (d >= 0) m_phase = d;
    if (m_mode == 0) begin
      if (d >= 0) begin m_mode = 1; m_run = 0; end
    end else if (m_mode == 1) begin
      if (!ok) m_mode = 0;
      else if (fwd) begin
        m_run++;
        if (m_run == 4) m_mode = 2;
      end
    end else begin
      if (!ok) begin
        m_mode = 0; m_err = 1;
        if (m_err_cnt < 255) m_err_cnt++;
      end else if (wrap) m_rev = (m_rev + 1) % 65536;
    end
    if (clr_v) begin m_err = 0; m_err_cnt = 0; m_rev = 0; end
    m_smp = code; m_smp_v = 1;
  endtask

  task automatic cycle(input logic [7:0] code, input bit clr_v, input bit r_v);
    jc_in = code; clr = clr_v; r = r_v;
    @(posedge clk);
    model_step(code, clr_v, r_v);
    #1;
  endtask

  task automatic advance(input bit clr_v);
    cur = (cur + 1) % P;
    cycle(code_of(cur), clr_v, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(code_of(5), 1'b1, 1'b1);
      checks++;
      if (act_vec() !== 31'd0) $display("FAIL reset got=%h exp=%h", act_vec(), 31'd0);
      else passed++;
    end
  endtask

  task automatic test_acquire();
    cur = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) cycle(code_of(0), 1'b0, 1'b0);
      else advance(1'b0);
      checks++;
      if (act_vec() !== exp_vec() || locked !== (i >= 5) || phase_vld !== (i >= 1) ||
          phase !== 4'(i >= 1 ? (i - 1) % P : 0))
        $display("FAIL acquire i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_revolution();
    int r0;
    int n;
    n = 0;
    while (!(m_phase == 0 && m_mode == 2) && n < 40) begin advance(1'b0); n++; end
    r0 = m_rev;
    for (int i = 0; i < 48; i++) begin
      advance(1'b0);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL rev_run i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if (rev_cnt !== 16'(r0 + 3) || err !== 1'b0 || n >= 40)
      $display("FAIL rev_count got=%0d exp=%0d err=%b", rev_cnt, r0 + 3, err);
    else passed++;
  endtask

  task automatic test_illegal();
    int e0;
    e0 = m_err_cnt;
    cycle(8'b10100000, 1'b0, 1'b0);
    advance(1'b0);
    checks++;
    if (phase_vld !== 1'b0 || locked !== 1'b0 || err !== 1'b1 || err_cnt !== 8'(e0 + 1))
      $display("FAIL illegal_code got=%h exp vld=0 lock=0 err=1 cnt=%0d", act_vec(), e0 + 1);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      advance(1'b0);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL relock i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if (locked !== 1'b1) $display("FAIL relock_final got=%b exp=1", locked);
    else passed++;
  endtask

  task automatic test_reverse_hold();
    int e0;
    int n;
    n = 0;
    while (!(cur == 5 && m_mode == 2) && n < 40) begin advance(1'b0); n++; end
    e0 = m_err_cnt;
    cur = 4;
    cycle(code_of(4), 1'b0, 1'b0);
    advance(1'b0);
    checks++;
    if (err_cnt !== 8'(e0 + 1) || locked !== 1'b0 || n >= 40)
      $display("FAIL reverse got cnt=%0d lock=%b exp cnt=%0d lock=0", err_cnt, locked, e0 + 1);
    else passed++;
    for (int i = 0; i < 6; i++) advance(1'b0);
    e0 = m_err_cnt;
    for (int i = 0; i < 3; i++) cycle(code_of(cur), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      advance(1'b0);
      checks++;
      if (locked !== 1'b1 || err_cnt !== 8'(e0) || act_vec() !== exp_vec())
        $display("FAIL hold i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_saturate();
    int bad;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 6; i++) advance(1'b0);
      cycle(8'b10100000, 1'b0, 1'b0);
      if (act_vec() !== exp_vec()) bad++;
    end
    advance(1'b0);
    checks++;
    if (err_cnt !== 8'd255 || bad != 0 || act_vec() !== exp_vec())
      $display("FAIL saturate got=%0d exp=255 mismatched_iters=%0d", err_cnt, bad);
    else passed++;
    for (int i = 0; i < 6; i++) advance(1'b0);
    cycle(8'b10100000, 1'b0, 1'b0);
    advance(1'b1);
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || locked !== 1'b0 || act_vec() !== exp_vec())
      $display("FAIL clr_vs_err got=%h exp err=0 cnt=0 lock=0", act_vec());
    else passed++;
  endtask

  task automatic test_random();
    int op;
    int d;
    logic [7:0] c;
    for (int i = 0; i < 500; i++) begin
      op = $urandom_range(99, 0);
      if (op < 60) advance(1'b0);
      else if (op < 75) cycle(code_of(cur), 1'b0, 1'b0);
      else if (op < 95) begin
        c = (op < 85) ? 8'($urandom) : code_of((cur + (op < 90 ? P - 1 : 2)) % P);
        d = model_decode(c);
        if (d >= 0) cur = d;
        cycle(c, 1'b0, 1'b0);
      end else advance(1'b1);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL random i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) advance(1'b0);
    while (!(m_phase == 9 && m_mode == 2) && n < 40) begin advance(1'b0); n++; end
    cycle(code_of((cur + 1) % P), 1'b0, 1'b1);
    checks++;
    if (act_vec() !== 31'd0 || n >= 40) $display("FAIL mid_reset got=%h exp=%h", act_vec(), 31'd0);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      advance(1'b0);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL post_reset i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if (locked !== 1'b1) $display("FAIL post_reset_lock got=%b exp=1", locked);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_revolution();
    test_illegal();
    test_reverse_hold();
    test_saturate();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 SHALL have parameter SIZE, default 7, where the code width is SIZE+1 bits and 2*(SIZE+1) phases exist.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, giving the consecutive legal advances needed to reach LOCKED.
REQ-003 SHALL have parameter REV_W, default 16, giving the revolution counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 r  input  1  reset, synchronous and active-high.
REQ-006 jc_in  input  [0:SIZE]  twisted-ring code from the upstream counter.
REQ-007 clr  input  1  synchronous clear of err, err_cnt and rev_cnt.
REQ-008 phase  output  clog2(2*(SIZE+1)) bits (4 at default)  decoded phase index.
REQ-009 phase_vld  output  1  the phase output is a legal decode.
REQ-010 locked  output  1  the FSM is in LOCKED.
REQ-011 err  output  1  sticky loss-of-lock flag.
REQ-012 err_cnt  output  8  saturating count of lock losses.
REQ-013 rev_cnt  output  REV_W  wrapping count of full revolutions while locked.

Function
REQ-014 Legal code for phase p (N = SIZE+1): if p <= N, bit i = 1 exactly when i < p; if p > N, bit i = 1 exactly when i >= p-N.
REQ-015 Any jc_in that matches no legal code SHALL be classed illegal.
REQ-016 Stage 1 SHALL register jc_in into a sample register every cycle.
REQ-017 Stage 2 SHALL decode the sample and compare it with the previous decoded phase.
REQ-018 All outputs SHALL be registered, with a latency of 2 clocks from jc_in to phase/phase_vld.
REQ-019 A transition is legal when the sample is a legal code and equals the previous phase (hold) or previous+1 mod 2N (advance); anything else is illegal, including reverse or skip steps.
REQ-020 FSM states: SEARCH, TRACK, LOCKED.
REQ-021 In SEARCH, a legal code SHALL move to TRACK with the advance counter set to 0.
REQ-022 In TRACK, each legal advance SHALL increment the advance counter; a hold leaves it unchanged; reaching LOCK_COUNT SHALL move to LOCKED; an illegal code or transition SHALL return to SEARCH with no error.
REQ-023 In LOCKED, an illegal code or transition SHALL: return to SEARCH, set err, and increment err_cnt (saturating at 255).
REQ-024 While LOCKED, each legal advance from phase 2N-1 to phase 0 SHALL increment rev_cnt, wrapping to 0.
REQ-025 phase_vld SHALL equal legality of the decoded sample; phase SHALL hold its last legal value while phase_vld = 0.
REQ-026 When clr coincides with an error event, clear SHALL take priority: err = 0 and err_cnt = 0.
REQ-027 When clr coincides with a wrap, clear SHALL take priority: rev_cnt = 0.
REQ-028 clr SHALL NOT affect the FSM state.

Reset
REQ-029 While r = 1, the block SHALL set: FSM = SEARCH, sample register = 0, phase = 0, phase_vld = 0, locked = 0, err = 0, err_cnt = 0, rev_cnt = 0, advance counter = 0.
REQ-030 r SHALL take priority over clr and all other inputs.
REQ-031 r asserted mid-operation SHALL discard lock within one edge.
REQ-032 The first valid phase_vld after reset release SHALL appear no earlier than the 2nd edge after release.

Structure
REQ-033 The FSM state encoding and the 8-bit err_cnt saturation limit SHALL live in a shared package johnson_pkg.
REQ-034 The code-to-phase decode (code in -> phase, legal out) SHALL be a combinational sub-module johnson_decode, reusable by other consumers.

Verification
REQ-035 Reset, then drive the free-running sequence 00000000, 10000000, 11000000, ... -> phase_vld = 1 two clocks later; locked = 1 after 4 advances; phase tracks 0..15.
REQ-036 Run locked for 48 cycles from phase 0 -> rev_cnt = 3, err = 0.
REQ-037 While locked, force jc_in = 10100000 for one cycle -> phase_vld = 0, locked = 0, err = 1, err_cnt = 1; relock after 4 legal advances.
REQ-038 While locked, step phase 5 -> 4 (reverse) -> err_cnt increments; separately, hold the same code 3 cycles -> no error, locked remains 1.
REQ-039 Inject 300 lock losses -> err_cnt = 255; assert clr on the same cycle as an error -> err = 0, err_cnt = 0.
REQ-040 Assert r while locked at phase 9 -> all outputs at reset values on the next edge; after release, normal relock.
